// File: rtl/pipe_pkg.sv
// Shared widths, the PC pseudo-register number and the RR/EX pipeline record
// for the register-read stage and its bypass selectors.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CTRL_W = 12;

  localparam logic [ADDR_W-1:0] REG_PC = 3'd7;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [ADDR_W-1:0] rd;
    logic              wr_rd;
    logic [CTRL_W-1:0] ctrl;
  } rr_bundle_t;

  // One forwarding source: a later stage that may be writing a register.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
  } fwd_src_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundles the decode-side inputs, register bank read port, forwarding buses
// and RR/EX outputs of the register-read stage.
interface operand_fetch_stage_if;
  import pipe_pkg::*;

  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic [ADDR_W-1:0] id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_wr_rd;
  logic [CTRL_W-1:0] id_ctrl;

  logic [ADDR_W-1:0] readAdd1;
  logic [ADDR_W-1:0] readAdd2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;

  logic              ex_wr_en;
  logic              ex_is_load;
  logic [ADDR_W-1:0] ex_wr_add;
  logic [DATA_W-1:0] ex_wr_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_add;
  logic [DATA_W-1:0] mem_wr_data;
  logic              wb_wr_en;
  logic [ADDR_W-1:0] wb_wr_add;
  logic [DATA_W-1:0] wb_wr_data;

  logic              ex_stall;
  logic              flush;
  logic              stall_out;

  logic              rr_valid;
  logic [DATA_W-1:0] rr_pc;
  logic [DATA_W-1:0] rr_opA;
  logic [DATA_W-1:0] rr_opB;
  logic [ADDR_W-1:0] rr_rd;
  logic              rr_wr_rd;
  logic [CTRL_W-1:0] rr_ctrl;

  // The stage itself.
  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_wr_rd, id_ctrl, readData1, readData2,
           ex_wr_en, ex_is_load, ex_wr_add, ex_wr_data,
           mem_wr_en, mem_wr_add, mem_wr_data,
           wb_wr_en, wb_wr_add, wb_wr_data, ex_stall, flush,
    output readAdd1, readAdd2, stall_out,
           rr_valid, rr_pc, rr_opA, rr_opB, rr_rd, rr_wr_rd, rr_ctrl
  );

  // The surrounding pipeline and register bank.
  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_wr_rd, id_ctrl, readData1, readData2,
           ex_wr_en, ex_is_load, ex_wr_add, ex_wr_data,
           mem_wr_en, mem_wr_add, mem_wr_data,
           wb_wr_en, wb_wr_add, wb_wr_data, ex_stall, flush,
    input  readAdd1, readAdd2, stall_out,
           rr_valid, rr_pc, rr_opA, rr_opB, rr_rd, rr_wr_rd, rr_ctrl
  );

endinterface

// File: rtl/operand_bypass_mux.sv
// Priority operand selector for one source register: PC pseudo-register,
// then EX, MEM and WB forwarding, then the bank read data.
module operand_bypass_mux
  import pipe_pkg::*;
(
  input  logic [ADDR_W-1:0] src_i,
  input  logic [DATA_W-1:0] pc_i,
  input  fwd_src_t          ex_i,
  input  logic              ex_is_load_i,
  input  fwd_src_t          mem_i,
  input  fwd_src_t          wb_i,
  input  logic [DATA_W-1:0] bank_i,
  output logic [DATA_W-1:0] op_o
);

  logic hit_ex, hit_mem, hit_wb;

  // A load in EX has no data yet; the hazard logic stalls instead.
  assign hit_ex  = ex_i.en  && (ex_i.add  == src_i) && !ex_is_load_i;
  assign hit_mem = mem_i.en && (mem_i.add == src_i);
  // The bank write lands on the same edge we capture, so WB must bypass too.
  assign hit_wb  = wb_i.en  && (wb_i.add  == src_i);

  always_comb begin
    op_o = bank_i;
    if (src_i == REG_PC)  op_o = pc_i;
    else if (hit_ex)      op_o = ex_i.data;
    else if (hit_mem)     op_o = mem_i.data;
    else if (hit_wb)      op_o = wb_i.data;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read stage: drives the bank read ports, forwards from EX/MEM/WB,
// inserts load-use bubbles and owns the RR/EX pipeline register.
module operand_fetch_stage
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  operand_fetch_stage_if.slave  bus
);

  fwd_src_t          ex_src, mem_src, wb_src;
  logic [DATA_W-1:0] opA_sel, opB_sel;
  logic              hz_rs1, hz_rs2, load_use;
  rr_bundle_t        rr_d, rr_q;

  assign bus.readAdd1 = bus.id_rs1;
  assign bus.readAdd2 = bus.id_rs2;

  assign ex_src  = '{en: bus.ex_wr_en,  add: bus.ex_wr_add,  data: bus.ex_wr_data};
  assign mem_src = '{en: bus.mem_wr_en, add: bus.mem_wr_add, data: bus.mem_wr_data};
  assign wb_src  = '{en: bus.wb_wr_en,  add: bus.wb_wr_add,  data: bus.wb_wr_data};

  operand_bypass_mux u_mux_rs1 (
    .src_i       (bus.id_rs1),
    .pc_i        (bus.id_pc),
    .ex_i        (ex_src),
    .ex_is_load_i(bus.ex_is_load),
    .mem_i       (mem_src),
    .wb_i        (wb_src),
    .bank_i      (bus.readData1),
    .op_o        (opA_sel)
  );

  operand_bypass_mux u_mux_rs2 (
    .src_i       (bus.id_rs2),
    .pc_i        (bus.id_pc),
    .ex_i        (ex_src),
    .ex_is_load_i(bus.ex_is_load),
    .mem_i       (mem_src),
    .wb_i        (wb_src),
    .bank_i      (bus.readData2),
    .op_o        (opB_sel)
  );

  // R7 is always the PC, so a load targeting it never creates a hazard.
  assign hz_rs1   = bus.id_use_rs1 && (bus.id_rs1 == bus.ex_wr_add) && (bus.id_rs1 != REG_PC);
  assign hz_rs2   = bus.id_use_rs2 && (bus.id_rs2 == bus.ex_wr_add) && (bus.id_rs2 != REG_PC);
  assign load_use = bus.id_valid && bus.ex_wr_en && bus.ex_is_load && (hz_rs1 || hz_rs2);

  assign bus.stall_out = !reset && !bus.flush && (bus.ex_stall || load_use);

  always_comb begin
    rr_d = rr_q;
    if (bus.flush) begin
      rr_d.valid = 1'b0;
    end else if (bus.ex_stall) begin
      rr_d = rr_q;
    end else if (load_use) begin
      rr_d.valid = 1'b0;
    end else begin
      rr_d.valid = bus.id_valid;
      rr_d.pc    = bus.id_pc;
      rr_d.opA   = opA_sel;
      rr_d.opB   = opB_sel;
      rr_d.rd    = bus.id_rd;
      rr_d.wr_rd = bus.id_wr_rd;
      rr_d.ctrl  = bus.id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign bus.rr_valid = rr_q.valid;
  assign bus.rr_pc    = rr_q.pc;
  assign bus.rr_opA   = rr_q.opA;
  assign bus.rr_opB   = rr_q.opB;
  assign bus.rr_rd    = rr_q.rd;
  assign bus.rr_wr_rd = rr_q.wr_rd;
  assign bus.rr_ctrl  = rr_q.ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for the register-read stage: reset, forwarding priority,
// PC pseudo-register, load-use bubble, stall, flush and reset mid-stall.
module tb_operand_fetch_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [DATA_W-1:0] bank [8];

  always #5 clk = ~clk;

  operand_fetch_stage_if ofs_if ();

  operand_fetch_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ofs_if.slave)
  );

  assign ofs_if.readData1 = bank[ofs_if.readAdd1];
  assign ofs_if.readData2 = bank[ofs_if.readAdd2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) bank[i] = 16'h0;
    reset = 1'b1;
    ofs_if.id_valid = 1'b1; ofs_if.id_pc = 16'h0010;
    ofs_if.id_rs1 = 3'd1; ofs_if.id_rs2 = 3'd2; ofs_if.id_rd = 3'd5;
    ofs_if.id_use_rs1 = 1'b1; ofs_if.id_use_rs2 = 1'b1; ofs_if.id_wr_rd = 1'b1;
    ofs_if.id_ctrl = 12'hABC;
    // Load-use condition present during reset: stall_out must stay low.
    ofs_if.ex_wr_en = 1'b1; ofs_if.ex_is_load = 1'b1; ofs_if.ex_wr_add = 3'd1;
    ofs_if.ex_wr_data = 16'h0;
    ofs_if.mem_wr_en = 1'b0; ofs_if.mem_wr_add = 3'd0; ofs_if.mem_wr_data = 16'h0;
    ofs_if.wb_wr_en = 1'b0; ofs_if.wb_wr_add = 3'd0; ofs_if.wb_wr_data = 16'h0;
    ofs_if.ex_stall = 1'b0; ofs_if.flush = 1'b0;

    step();
    chk("rst_valid", ofs_if.rr_valid, 0);
    chk("rst_opA", ofs_if.rr_opA, 0);
    chk("rst_opB", ofs_if.rr_opB, 0);
    chk("rst_ctrl", ofs_if.rr_ctrl, 0);
    chk("rst_stall_out", ofs_if.stall_out, 0);

    // Plain bank read after reset release.
    reset = 1'b0;
    ofs_if.ex_wr_en = 1'b0; ofs_if.ex_is_load = 1'b0;
    bank[1] = 16'h0001; bank[2] = 16'h0002;
    settle();
    chk("rd_addr1", ofs_if.readAdd1, 1);
    chk("rd_addr2", ofs_if.readAdd2, 2);
    step();
    chk("bank_valid", ofs_if.rr_valid, 1);
    chk("bank_opA", ofs_if.rr_opA, 16'h0001);
    chk("bank_opB", ofs_if.rr_opB, 16'h0002);
    chk("bank_pc", ofs_if.rr_pc, 16'h0010);
    chk("bank_rd", ofs_if.rr_rd, 5);
    chk("bank_wr_rd", ofs_if.rr_wr_rd, 1);
    chk("bank_ctrl", ofs_if.rr_ctrl, 12'hABC);

    // Forwarding priority on rs1 = R3.
    bank[3] = 16'h3333;
    ofs_if.id_rs1 = 3'd3;
    ofs_if.ex_wr_en = 1'b1; ofs_if.ex_wr_add = 3'd3; ofs_if.ex_wr_data = 16'hAAAA;
    ofs_if.mem_wr_en = 1'b1; ofs_if.mem_wr_add = 3'd3; ofs_if.mem_wr_data = 16'hBBBB;
    ofs_if.wb_wr_en = 1'b1; ofs_if.wb_wr_add = 3'd3; ofs_if.wb_wr_data = 16'hCCCC;
    step();
    chk("fwd_ex", ofs_if.rr_opA, 16'hAAAA);
    chk("fwd_ex_opB", ofs_if.rr_opB, 16'h0002);
    ofs_if.ex_wr_en = 1'b0;
    step();
    chk("fwd_mem", ofs_if.rr_opA, 16'hBBBB);
    ofs_if.mem_wr_en = 1'b0;
    step();
    chk("fwd_wb", ofs_if.rr_opA, 16'hCCCC);
    ofs_if.wb_wr_en = 1'b0;
    step();
    chk("fwd_none", ofs_if.rr_opA, 16'h3333);

    // R7 reads return the PC, even with EX writing R7 (and a load to R7 never stalls).
    bank[7] = 16'h7777;
    ofs_if.id_rs2 = 3'd7; ofs_if.id_pc = 16'h0040;
    ofs_if.ex_wr_en = 1'b1; ofs_if.ex_wr_add = 3'd7; ofs_if.ex_wr_data = 16'h1234;
    step();
    chk("r7_opB", ofs_if.rr_opB, 16'h0040);
    ofs_if.ex_is_load = 1'b1;
    settle();
    chk("r7_load_nostall", ofs_if.stall_out, 0);

    // Load-use on R4: one-cycle bubble, then MEM bypass supplies the value.
    bank[4] = 16'h4444;
    ofs_if.id_rs1 = 3'd4; ofs_if.id_rs2 = 3'd2; ofs_if.id_pc = 16'h0050;
    ofs_if.ex_wr_add = 3'd4; ofs_if.ex_wr_data = 16'hDEAD;
    settle();
    chk("lu_stall_out", ofs_if.stall_out, 1);
    step();
    chk("lu_bubble", ofs_if.rr_valid, 0);
    chk("lu_pc_hold", ofs_if.rr_pc, 16'h0040);
    ofs_if.ex_wr_en = 1'b0; ofs_if.ex_is_load = 1'b0;
    ofs_if.mem_wr_en = 1'b1; ofs_if.mem_wr_add = 3'd4; ofs_if.mem_wr_data = 16'h5555;
    settle();
    chk("lu_release", ofs_if.stall_out, 0);
    step();
    chk("lu_valid", ofs_if.rr_valid, 1);
    chk("lu_opA", ofs_if.rr_opA, 16'h5555);
    chk("lu_pc", ofs_if.rr_pc, 16'h0050);

    // Downstream stall holds the RR/EX register for three cycles.
    ofs_if.mem_wr_en = 1'b0;
    ofs_if.ex_stall = 1'b1; ofs_if.id_rs1 = 3'd1; ofs_if.id_pc = 16'h0060;
    ofs_if.id_ctrl = 12'h123;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("stl_stall_out", ofs_if.stall_out, 1);
      step();
      chk("stl_opA", ofs_if.rr_opA, 16'h5555);
      chk("stl_pc", ofs_if.rr_pc, 16'h0050);
      chk("stl_ctrl", ofs_if.rr_ctrl, 12'hABC);
      chk("stl_valid", ofs_if.rr_valid, 1);
    end
    ofs_if.ex_stall = 1'b0;

    // Flush together with load-use: flush wins, no stall request.
    ofs_if.id_rs1 = 3'd4;
    ofs_if.ex_wr_en = 1'b1; ofs_if.ex_is_load = 1'b1; ofs_if.ex_wr_add = 3'd4;
    ofs_if.flush = 1'b1;
    settle();
    chk("fl_stall_out", ofs_if.stall_out, 0);
    step();
    chk("fl_valid", ofs_if.rr_valid, 0);

    // Capture a valid instruction, then reset during a stall clears everything.
    ofs_if.flush = 1'b0; ofs_if.ex_wr_en = 1'b0; ofs_if.ex_is_load = 1'b0;
    ofs_if.id_rs1 = 3'd1; ofs_if.id_pc = 16'h0070;
    step();
    chk("pre_rst_valid", ofs_if.rr_valid, 1);
    chk("pre_rst_opA", ofs_if.rr_opA, 16'h0001);
    ofs_if.ex_stall = 1'b1; reset = 1'b1;
    settle();
    chk("mid_rst_stall_out", ofs_if.stall_out, 0);
    step();
    chk("mid_rst_valid", ofs_if.rr_valid, 0);
    chk("mid_rst_opA", ofs_if.rr_opA, 0);
    chk("mid_rst_pc", ofs_if.rr_pc, 0);
    chk("mid_rst_wr_rd", ofs_if.rr_wr_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
